// File: rtl/id_stage_pkg.sv
// Shared decode constants, control-bundle layout and ID/EX register type for id_stage.
package id_stage_pkg;

  localparam int          XLEN      = 32;
  localparam int          REG_COUNT = 32;
  localparam int          ADDR_W    = 5;
  localparam logic [31:0] NOP_INS   = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int CTRL_W        = 10;
  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_JUMP     = 2;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Field order matches the CTRL_* bit indices so the struct packs straight onto E_Ctrl.
  typedef struct packed {
    logic    regWrite;
    logic    memRead;
    logic    memWrite;
    logic    memToReg;
    logic    aluSrc;
    logic    regDst;
    logic    branch;
    logic    jump;
    alu_op_e aluOp;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   jTarget;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [5:0]        funct;
    ctrl_t             ctrl;
    logic              illegal;
  } idex_t;

  function automatic logic usesRt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// write-through bypass on same-cycle read/write, and $0 hardwired to zero.
module id_stage_reg_file
  import id_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic            wrValid;

  assign wrValid = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrValid) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A write landing this cycle is forwarded so decode sees the value being retired.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (wrValid && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (wrValid && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS-subset decode stage: IF/ID register, decoder, load-use hazard detection,
// register file read and the registered ID/EX bundle feeding execute.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [XLEN-1:0]     Ins,
  input  logic [XLEN-1:0]     nextPC,
  input  logic                Flush,
  input  logic                WB_WE,
  input  logic [ADDR_W-1:0]   WB_Addr,
  input  logic [XLEN-1:0]     WB_Data,
  output logic                Stall,
  output logic [XLEN-1:0]     E_PC4,
  output logic [XLEN-1:0]     E_RD1,
  output logic [XLEN-1:0]     E_RD2,
  output logic [XLEN-1:0]     E_Imm,
  output logic [XLEN-1:0]     E_JTarget,
  output logic [ADDR_W-1:0]   E_Rs,
  output logic [ADDR_W-1:0]   E_Rt,
  output logic [ADDR_W-1:0]   E_Rd,
  output logic [5:0]          E_Funct,
  output logic [CTRL_W-1:0]   E_Ctrl,
  output logic                E_Illegal
);

  logic [XLEN-1:0]   ifIdIns_q,  ifIdIns_d;
  logic [XLEN-1:0]   ifIdPc4_q,  ifIdPc4_d;
  idex_t             idEx_q,     idEx_d;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;
  ctrl_t             ctrl;
  logic              legal;
  logic              hazard;

  assign opcode = ifIdIns_q[31:26];
  assign rs     = ifIdIns_q[25:21];
  assign rt     = ifIdIns_q[20:16];
  assign rd     = ifIdIns_q[15:11];
  assign funct  = ifIdIns_q[5:0];

  id_stage_reg_file u_regFile (
    .clk_i    (CLK),
    .rst_i    (RST),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rd1),
    .rdata2_o (rd2),
    .we_i     (WB_WE),
    .waddr_i  (WB_Addr),
    .wdata_i  (WB_Data)
  );

  // The all-zero bubble is the one sll form accepted; any other funct outside the list is illegal.
  always_comb begin
    ctrl  = '0;
    legal = 1'b1;
    if (ifIdIns_q != NOP_INS) begin
      unique case (opcode)
        OP_RTYPE: begin
          unique case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
              ctrl.regWrite = 1'b1;
              ctrl.regDst   = 1'b1;
              ctrl.aluOp    = ALUOP_FUNCT;
            end
            default: legal = 1'b0;
          endcase
        end
        OP_LW: begin
          ctrl.regWrite = 1'b1;
          ctrl.memRead  = 1'b1;
          ctrl.memToReg = 1'b1;
          ctrl.aluSrc   = 1'b1;
        end
        OP_SW: begin
          ctrl.memWrite = 1'b1;
          ctrl.aluSrc   = 1'b1;
        end
        OP_BEQ: begin
          ctrl.branch = 1'b1;
          ctrl.aluOp  = ALUOP_SUB;
        end
        OP_ADDI: begin
          ctrl.regWrite = 1'b1;
          ctrl.aluSrc   = 1'b1;
        end
        OP_J:    ctrl.jump = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

  // A load in EX whose destination feeds this instruction costs exactly one bubble.
  always_comb begin
    hazard = idEx_q.ctrl.memRead && (idEx_q.rt != '0) && legal &&
             ((idEx_q.rt == rs) || ((idEx_q.rt == rt) && usesRt(opcode)));
    Stall  = hazard && !Flush;
  end

  always_comb begin
    ifIdIns_d = Ins;
    ifIdPc4_d = nextPC;
    if (Flush) begin
      ifIdIns_d = NOP_INS;
      ifIdPc4_d = '0;
    end else if (Stall) begin
      ifIdIns_d = ifIdIns_q;
      ifIdPc4_d = ifIdPc4_q;
    end
  end

  always_comb begin
    idEx_d = '0;
    if (!Flush && !Stall) begin
      if (legal) begin
        idEx_d.pc4     = ifIdPc4_q;
        idEx_d.rd1     = rd1;
        idEx_d.rd2     = rd2;
        idEx_d.imm     = {{16{ifIdIns_q[15]}}, ifIdIns_q[15:0]};
        idEx_d.jTarget = {ifIdPc4_q[31:28], ifIdIns_q[25:0], 2'b00};
        idEx_d.rs      = rs;
        idEx_d.rt      = rt;
        idEx_d.rd      = rd;
        idEx_d.funct   = funct;
        idEx_d.ctrl    = ctrl;
      end else begin
        idEx_d.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ifIdIns_q <= NOP_INS;
      ifIdPc4_q <= '0;
      idEx_q    <= '0;
    end else begin
      ifIdIns_q <= ifIdIns_d;
      ifIdPc4_q <= ifIdPc4_d;
      idEx_q    <= idEx_d;
    end
  end

  assign E_PC4     = idEx_q.pc4;
  assign E_RD1     = idEx_q.rd1;
  assign E_RD2     = idEx_q.rd2;
  assign E_Imm     = idEx_q.imm;
  assign E_JTarget = idEx_q.jTarget;
  assign E_Rs      = idEx_q.rs;
  assign E_Rt      = idEx_q.rt;
  assign E_Rd      = idEx_q.rd;
  assign E_Funct   = idEx_q.funct;
  assign E_Ctrl    = idEx_q.ctrl;
  assign E_Illegal = idEx_q.illegal;

endmodule
